// File: rtl/pe_host_loader.sv
// Host-side loader for the SIMD core: turns a command/data word stream into instruction
// and operand RAM writes, kicks the core, and streams result rows back out lane by lane.
module pe_host_loader #(
    parameter int DATA_LEN    = 32,
    parameter int PE_ELEMENTS = 4,
    parameter int INST_LEN    = 12,
    parameter int PC_LEN      = 12,
    parameter int DRAM_DEPTH  = 256,
    parameter int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_LEN-1:0]             s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_LEN-1:0]             m_data,
    output logic                            inst_wr_en,
    output logic [PC_LEN-1:0]               inst_wr_addr,
    output logic [INST_LEN-1:0]             inst_wr_data,
    output logic                            ram_a_wr_en,
    output logic [DRAM_ADDR_WIDTH-1:0]      ram_a_wr_addr,
    output logic [PE_ELEMENTS*DATA_LEN-1:0] ram_a_wr_data,
    output logic                            ram_b_wr_en,
    output logic [DRAM_ADDR_WIDTH-1:0]      ram_b_wr_addr,
    output logic [PE_ELEMENTS*DATA_LEN-1:0] ram_b_wr_data,
    output logic                            res_rd_en,
    output logic [DRAM_ADDR_WIDTH-1:0]      res_rd_addr,
    input  logic [PE_ELEMENTS*DATA_LEN-1:0] res_rd_data,
    output logic                            core_start,
    input  logic                            core_done,
    output logic                            busy,
    output logic                            err
);

    localparam int ROW_W  = PE_ELEMENTS * DATA_LEN;
    localparam int LANE_W = (PE_ELEMENTS > 1) ? $clog2(PE_ELEMENTS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PE_ELEMENTS - 1);

    localparam logic [3:0] CMD_LOAD_INST = 4'd0;
    localparam logic [3:0] CMD_LOAD_A    = 4'd1;
    localparam logic [3:0] CMD_LOAD_B    = 4'd2;
    localparam logic [3:0] CMD_RUN       = 4'd3;
    localparam logic [3:0] CMD_READ_RES  = 4'd4;

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD_INST,
        S_LOAD_ROW,
        S_START,
        S_WAIT_DONE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_SEND
    } state_t;

    state_t state, state_next;

    logic [11:0]       count;
    logic [11:0]       base;
    logic [11:0]       item_cnt;
    logic [LANE_W-1:0] lane_cnt;
    logic              load_b;
    logic [ROW_W-1:0]  row_buf;
    logic [ROW_W-1:0]  row_next;
    logic [ROW_W-1:0]  res_buf;

    logic        s_fire;
    logic        m_fire;
    logic        last_item;
    logic        last_lane;
    logic [3:0]  hdr_cmd;
    logic [11:0] hdr_count;
    logic [11:0] hdr_base;

    assign hdr_cmd   = s_data[31:28];
    assign hdr_count = s_data[27:16];
    assign hdr_base  = s_data[11:0];
    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    assign last_item = (item_cnt == count - 12'd1);
    assign last_lane = (lane_cnt == LAST_LANE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus all outputs that follow directly from the current state.
    always_comb begin
        state_next  = state;
        s_ready     = 1'b0;
        busy        = 1'b1;
        core_start  = 1'b0;
        res_rd_en   = 1'b0;
        res_rd_addr = DRAM_ADDR_WIDTH'(base) + DRAM_ADDR_WIDTH'(item_cnt);
        m_valid     = 1'b0;
        m_data      = res_buf[lane_cnt*DATA_LEN +: DATA_LEN];
        row_next    = row_buf;
        row_next[lane_cnt*DATA_LEN +: DATA_LEN] = s_data;

        case (state)
            S_HDR: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_fire) begin
                    case (hdr_cmd)
                        CMD_LOAD_INST: if (hdr_count != 12'd0) state_next = S_LOAD_INST;
                        CMD_LOAD_A,
                        CMD_LOAD_B:    if (hdr_count != 12'd0) state_next = S_LOAD_ROW;
                        CMD_RUN:       state_next = S_START;
                        CMD_READ_RES:  if (hdr_count != 12'd0) state_next = S_RD_REQ;
                        default:       state_next = S_HDR;
                    endcase
                end
            end
            S_LOAD_INST: begin
                s_ready = 1'b1;
                if (s_fire && last_item) state_next = S_HDR;
            end
            S_LOAD_ROW: begin
                s_ready = 1'b1;
                if (s_fire && last_lane && last_item) state_next = S_HDR;
            end
            S_START: begin
                core_start = 1'b1;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (core_done) state_next = S_HDR;
            end
            S_RD_REQ: begin
                res_rd_en  = 1'b1;
                state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_next = S_RD_SEND;
            end
            S_RD_SEND: begin
                m_valid = 1'b1;
                if (m_fire && last_lane) state_next = last_item ? S_HDR : S_RD_REQ;
            end
            default: state_next = S_HDR;
        endcase
    end

    // Datapath: header capture, item/lane counters, row assembly and the registered write ports.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count         <= '0;
            base          <= '0;
            item_cnt      <= '0;
            lane_cnt      <= '0;
            load_b        <= 1'b0;
            row_buf       <= '0;
            res_buf       <= '0;
            err           <= 1'b0;
            inst_wr_en    <= 1'b0;
            inst_wr_addr  <= '0;
            inst_wr_data  <= '0;
            ram_a_wr_en   <= 1'b0;
            ram_a_wr_addr <= '0;
            ram_a_wr_data <= '0;
            ram_b_wr_en   <= 1'b0;
            ram_b_wr_addr <= '0;
            ram_b_wr_data <= '0;
        end else begin
            inst_wr_en  <= 1'b0;
            ram_a_wr_en <= 1'b0;
            ram_b_wr_en <= 1'b0;

            case (state)
                S_HDR: begin
                    if (s_fire) begin
                        count    <= hdr_count;
                        base     <= hdr_base;
                        load_b   <= (hdr_cmd == CMD_LOAD_B);
                        item_cnt <= '0;
                        lane_cnt <= '0;
                        if (hdr_cmd > CMD_READ_RES) err <= 1'b1;
                    end
                end
                S_LOAD_INST: begin
                    if (s_fire) begin
                        inst_wr_en   <= 1'b1;
                        inst_wr_addr <= PC_LEN'(base) + PC_LEN'(item_cnt);
                        inst_wr_data <= s_data[INST_LEN-1:0];
                        item_cnt     <= item_cnt + 12'd1;
                    end
                end
                S_LOAD_ROW: begin
                    if (s_fire) begin
                        row_buf <= row_next;
                        if (last_lane) begin
                            lane_cnt <= '0;
                            item_cnt <= item_cnt + 12'd1;
                            if (load_b) begin
                                ram_b_wr_en   <= 1'b1;
                                ram_b_wr_addr <= DRAM_ADDR_WIDTH'(base) + DRAM_ADDR_WIDTH'(item_cnt);
                                ram_b_wr_data <= row_next;
                            end else begin
                                ram_a_wr_en   <= 1'b1;
                                ram_a_wr_addr <= DRAM_ADDR_WIDTH'(base) + DRAM_ADDR_WIDTH'(item_cnt);
                                ram_a_wr_data <= row_next;
                            end
                        end else begin
                            lane_cnt <= lane_cnt + LANE_W'(1);
                        end
                    end
                end
                S_RD_WAIT: begin
                    res_buf  <= res_rd_data;
                    lane_cnt <= '0;
                end
                S_RD_SEND: begin
                    if (m_fire) begin
                        if (last_lane) begin
                            lane_cnt <= '0;
                            item_cnt <= item_cnt + 12'd1;
                        end else begin
                            lane_cnt <= lane_cnt + LANE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_host_loader.sv
// Directed bench for pe_host_loader: table of load vectors plus hand-written RUN, READ_RES
// and mid-row reset sequences, all against hand-computed expectations.
module tb_pe_host_loader;

    localparam int DATA_LEN    = 32;
    localparam int PE_ELEMENTS = 4;
    localparam int INST_LEN    = 12;
    localparam int PC_LEN      = 12;
    localparam int DRAM_DEPTH  = 256;
    localparam int AW          = 8;
    localparam int RW          = PE_ELEMENTS * DATA_LEN;

    logic                clk = 1'b0;
    logic                rstn;
    logic                s_valid;
    logic                s_ready;
    logic [DATA_LEN-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic [DATA_LEN-1:0] m_data;
    logic                inst_wr_en;
    logic [PC_LEN-1:0]   inst_wr_addr;
    logic [INST_LEN-1:0] inst_wr_data;
    logic                ram_a_wr_en;
    logic [AW-1:0]       ram_a_wr_addr;
    logic [RW-1:0]       ram_a_wr_data;
    logic                ram_b_wr_en;
    logic [AW-1:0]       ram_b_wr_addr;
    logic [RW-1:0]       ram_b_wr_data;
    logic                res_rd_en;
    logic [AW-1:0]       res_rd_addr;
    logic [RW-1:0]       res_rd_data;
    logic                core_start;
    logic                core_done;
    logic                busy;
    logic                err;

    pe_host_loader #(
        .DATA_LEN(DATA_LEN), .PE_ELEMENTS(PE_ELEMENTS), .INST_LEN(INST_LEN),
        .PC_LEN(PC_LEN), .DRAM_DEPTH(DRAM_DEPTH), .DRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .inst_wr_en(inst_wr_en), .inst_wr_addr(inst_wr_addr), .inst_wr_data(inst_wr_data),
        .ram_a_wr_en(ram_a_wr_en), .ram_a_wr_addr(ram_a_wr_addr), .ram_a_wr_data(ram_a_wr_data),
        .ram_b_wr_en(ram_b_wr_en), .ram_b_wr_addr(ram_b_wr_addr), .ram_b_wr_data(ram_b_wr_data),
        .res_rd_en(res_rd_en), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
        .core_start(core_start), .core_done(core_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Result RAM with one cycle read latency.
    logic [RW-1:0] res_mem [0:DRAM_DEPTH-1];
    always @(posedge clk) if (res_rd_en) res_rd_data <= res_mem[res_rd_addr];

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        ei;
        logic        ea;
        logic        eb;
        logic [11:0] addr;
        logic [RW-1:0] data;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   num_vec  = 0;
    int   num_fail = 0;

    int          start_cnt  = 0;
    int          a_wr_cnt   = 0;
    int          stall_viol = 0;
    logic [31:0] rx[$];
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (ram_a_wr_en) a_wr_cnt++;
        if (pv && !pr && (!m_valid || m_data !== pd)) stall_viol++;
        if (m_valid && m_ready) rx.push_back(m_data);
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        num_vec++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic sv, input logic [31:0] sd, input logic ei, input logic ea,
                          input logic eb, input logic [11:0] addr, input logic [RW-1:0] data,
                          input logic bsy, input logic er);
        vec_t v;
        v.sv = sv; v.sd = sd; v.ei = ei; v.ea = ea; v.eb = eb;
        v.addr = addr; v.data = data; v.busy = bsy; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        s_valid = v.sv;
        s_data  = v.sd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("vec%0d inst_wr_en", idx), RW'(inst_wr_en), RW'(v.ei));
        check($sformatf("vec%0d ram_a_wr_en", idx), RW'(ram_a_wr_en), RW'(v.ea));
        check($sformatf("vec%0d ram_b_wr_en", idx), RW'(ram_b_wr_en), RW'(v.eb));
        check($sformatf("vec%0d s_ready", idx), RW'(s_ready), RW'(1'b1));
        check($sformatf("vec%0d busy", idx), RW'(busy), RW'(v.busy));
        check($sformatf("vec%0d err", idx), RW'(err), RW'(v.err));
        if (v.ei) begin
            check($sformatf("vec%0d inst_wr_addr", idx), RW'(inst_wr_addr), RW'(v.addr));
            check($sformatf("vec%0d inst_wr_data", idx), RW'(inst_wr_data), v.data);
        end
        if (v.ea) begin
            check($sformatf("vec%0d ram_a_wr_addr", idx), RW'(ram_a_wr_addr), RW'(v.addr));
            check($sformatf("vec%0d ram_a_wr_data", idx), ram_a_wr_data, v.data);
        end
        if (v.eb) begin
            check($sformatf("vec%0d ram_b_wr_addr", idx), RW'(ram_b_wr_addr), RW'(v.addr));
            check($sformatf("vec%0d ram_b_wr_data", idx), ram_b_wr_data, v.data);
        end
    endtask

    function automatic logic [7:0] outs_vec();
        return {busy, err, inst_wr_en, ram_a_wr_en, ram_b_wr_en, res_rd_en, core_start, m_valid};
    endfunction

    initial begin
        int cyc;
        int a0;
        int s0;
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; core_done = 1'b0;
        for (int i = 0; i < DRAM_DEPTH; i++) res_mem[i] = '0;
        res_mem[8'h10] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        res_mem[8'h11] = {32'hA7, 32'hA6, 32'hA5, 32'hA4};

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", RW'(outs_vec()), RW'(8'h00));
        @(negedge clk);
        rstn = 1'b1;

        // LOAD_INST base 5, count 3, with a gap after the first word
        addVec(1, 32'h0003_0005, 0, 0, 0, 12'h000, '0, 1, 0);
        addVec(1, 32'hFFFF_FA01, 1, 0, 0, 12'h005, RW'(12'hA01), 1, 0);
        addVec(0, 32'h0000_0000, 0, 0, 0, 12'h000, '0, 1, 0);
        addVec(1, 32'h1234_5B02, 1, 0, 0, 12'h006, RW'(12'hB02), 1, 0);
        addVec(1, 32'h0000_0C03, 1, 0, 0, 12'h007, RW'(12'hC03), 0, 0);
        addVec(0, 32'h0000_0000, 0, 0, 0, 12'h000, '0, 0, 0);
        // LOAD_A base 0xFE count 2, words 1..8
        addVec(1, 32'h1002_00FE, 0, 0, 0, 12'h000, '0, 1, 0);
        for (int w = 1; w <= 8; w++)
            addVec(1, 32'(w), 0, (w == 4 || w == 8), 0, (w == 4) ? 12'h0FE : 12'h0FF,
                   (w == 4) ? {32'd4, 32'd3, 32'd2, 32'd1} : {32'd8, 32'd7, 32'd6, 32'd5},
                   (w != 8), 0);
        // LOAD_B base 0xFF count 2 wraps to row 0
        addVec(1, 32'h2002_00FF, 0, 0, 0, 12'h000, '0, 1, 0);
        for (int w = 9; w <= 16; w++)
            addVec(1, 32'(w), 0, 0, (w == 12 || w == 16), (w == 12) ? 12'h0FF : 12'h000,
                   (w == 12) ? {32'd12, 32'd11, 32'd10, 32'd9} : {32'd16, 32'd15, 32'd14, 32'd13},
                   (w != 16), 0);
        // count 0 LOAD_A, then a bad command, then a valid LOAD_INST
        addVec(1, 32'h1000_0010, 0, 0, 0, 12'h000, '0, 0, 0);
        addVec(0, 32'h0000_0000, 0, 0, 0, 12'h000, '0, 0, 0);
        addVec(1, 32'hF000_0000, 0, 0, 0, 12'h000, '0, 0, 1);
        addVec(1, 32'h0001_0100, 0, 0, 0, 12'h000, '0, 1, 1);
        addVec(1, 32'h0000_0123, 1, 0, 0, 12'h100, RW'(12'h123), 0, 1);
        addVec(0, 32'h0000_0000, 0, 0, 0, 12'h000, '0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end
        @(negedge clk);
        s_valid = 1'b0;

        // RUN: stray core_done in HDR is ignored, then one start pulse and a 20-cycle wait
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("stray done busy", RW'(busy), RW'(1'b0));
        s0 = start_cnt;
        s_valid = 1'b1;
        s_data  = 32'h3FFF_FFFF;
        @(posedge clk);
        #1;
        check("run core_start", RW'(core_start), RW'(1'b1));
        check("run s_ready", RW'(s_ready), RW'(1'b0));
        check("run busy", RW'(busy), RW'(1'b1));
        @(negedge clk);
        s_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("wait busy", RW'(busy), RW'(1'b1));
        check("wait s_ready", RW'(s_ready), RW'(1'b0));
        check("start pulses", RW'(start_cnt - s0), RW'(1));
        core_done = 1'b1;
        @(posedge clk);
        #1;
        check("done busy", RW'(busy), RW'(1'b0));
        check("done s_ready", RW'(s_ready), RW'(1'b1));
        @(negedge clk);
        core_done = 1'b0;

        // READ_RES base 0x10 count 2 with m_ready toggling every cycle
        rx.delete();
        s_valid = 1'b1;
        s_data  = 32'h4002_0010;
        @(negedge clk);
        s_valid = 1'b0;
        cyc = 0;
        while ((rx.size() < 8 || busy) && cyc < 300) begin
            @(posedge clk);
            #1;
            m_ready = ~m_ready;
            cyc++;
        end
        m_ready = 1'b0;
        check("read finished in time", RW'(cyc < 300), RW'(1'b1));
        check("read word count", RW'(rx.size()), RW'(8));
        for (int i = 0; i < 8; i++)
            check($sformatf("read lane %0d", i), RW'((i < rx.size()) ? rx[i] : 32'hDEAD_BEEF),
                  RW'(32'hA0 + i));
        check("stall stability", RW'(stall_viol), RW'(0));

        // Reset after two of four lanes: nothing written, outputs cleared
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'h1001_0020;
        @(negedge clk);
        s_data  = 32'h0000_0011;
        @(negedge clk);
        s_data  = 32'h0000_0022;
        @(negedge clk);
        s_valid = 1'b0;
        a0 = a_wr_cnt;
        rstn = 1'b0;
        #1;
        check("midrow reset outputs", RW'(outs_vec()), RW'(8'h00));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check("midrow no write", RW'(a_wr_cnt - a0), RW'(0));

        s_valid = 1'b1;
        s_data  = 32'h1001_0030;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            s_data = 32'h11 + 32'(w);
        end
        @(posedge clk);
        #1;
        check("fresh load wr_en", RW'(ram_a_wr_en), RW'(1'b1));
        check("fresh load addr", RW'(ram_a_wr_addr), RW'(8'h30));
        check("fresh load data", ram_a_wr_data, {32'h14, 32'h13, 32'h12, 32'h11});
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fresh load one write", RW'(a_wr_cnt - a0), RW'(1));
        check("fresh load idle", RW'(busy), RW'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_fail);
        $finish;
    end

endmodule
